ref_bank_ring: RTL and testbench



---
 rtl/me_pkg.sv | 14 +
 rtl/ref_bank_mem.sv | 30 +++
 rtl/ref_bank_ring.sv | 141 ++++++++++++++
 tb/tb_ref_bank_ring.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and helpers for the motion-estimation datapath.
package me_pkg;

    localparam int PIX_W            = 8;   // bits per pixel
    localparam int DEF_PIX_PER_WORD = 8;   // pixels packed into one bank word
    localparam int DEF_DEPTH        = 96;  // words per reference bank
    localparam int DEF_SEG_LEN      = 24;  // words per write segment

    // Address width for n locations; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ref_bank_mem.sv
// Simple dual-port RAM: one write port, one synchronous read-first read port.
// Kept separate so a foundry macro can replace it without touching the ring.
module ref_bank_mem #(
    parameter int DW    = 64,
    parameter int DEPTH = 96,
    localparam int AW   = me_pkg::addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read port; a same-address read returns the old word.
    // NOTE: the array has no reset so it maps onto plain RAM; consumers must qualify rd.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/ref_bank_ring.sv
// Reference-pixel bank for the search-window buffer: circular segment-wise
// writes, per-segment validity tracking, one registered random read per cycle.
module ref_bank_ring #(
    parameter int PIX_W        = me_pkg::PIX_W,
    parameter int PIX_PER_WORD = me_pkg::DEF_PIX_PER_WORD,
    parameter int DEPTH        = me_pkg::DEF_DEPTH,
    parameter int SEG_LEN      = me_pkg::DEF_SEG_LEN,
    localparam int DW          = PIX_W * PIX_PER_WORD,
    localparam int AW          = me_pkg::addr_width(DEPTH),
    localparam int NSEG        = DEPTH / SEG_LEN,
    localparam int SW          = me_pkg::addr_width(NSEG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          wr_en,
    input  logic          bank_sel,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_miss,
    output logic [AW-1:0] wr_ptr,
    output logic          seg_done,
    output logic [SW-1:0] seg_idx,
    output logic          full
);

    localparam int OW = me_pkg::addr_width(SEG_LEN);

    // The segment bookkeeping assumes the ring is tiled exactly by segments.
    if (DEPTH % SEG_LEN != 0) begin : g_bad_seg_len
        $error("ref_bank_ring: DEPTH (%0d) must be a multiple of SEG_LEN (%0d)", DEPTH, SEG_LEN);
    end

    logic [SW-1:0]   wr_seg;        // segment currently being written
    logic [OW-1:0]   seg_off;       // offset of wr_ptr inside wr_seg
    logic [NSEG-1:0] seg_valid;
    logic [NSEG-1:0] seg_valid_nxt;
    logic            wr_fire;
    logic            seg_first;
    logic            seg_last;
    logic [31:0]     rd_addr_i;
    logic            rd_hit_c;
    logic            hit_q;         // previous read hit: mem output is meaningful
    logic [DW-1:0]   mem_q;

    assign wr_fire   = wr_en && bank_sel;
    assign seg_first = (seg_off == '0);
    assign seg_last  = (seg_off == OW'(SEG_LEN - 1));
    assign rd_addr_i = 32'(rd_addr);

    // Next segment-valid vector for a write: entering a segment clears it,
    // finishing it sets it; set is applied last so it wins when SEG_LEN==1.
    // NOTE: the default copy at the top keeps every path assigned, so no latch.
    always_comb begin
        seg_valid_nxt = seg_valid;
        if (wr_fire) begin
            if (seg_first) seg_valid_nxt[wr_seg] = 1'b0;
            if (seg_last)  seg_valid_nxt[wr_seg] = 1'b1;
        end
    end

    // Read lookup: hit only if the address falls inside a valid segment;
    // addresses at or beyond DEPTH match no segment and therefore miss.
    always_comb begin
        rd_hit_c = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            if (rd_addr_i >= 32'(k * SEG_LEN) && rd_addr_i < 32'((k + 1) * SEG_LEN)) begin
                rd_hit_c = seg_valid[k];
            end
        end
    end

    // Write pointer, segment counter, validity vector and completion strobes.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            wr_seg    <= '0;
            seg_off   <= '0;
            seg_valid <= '0;
            seg_done  <= 1'b0;
            seg_idx   <= '0;
            full      <= 1'b0;
        end else if (frame_start) begin
            // Restart beats a same-cycle write; that write is dropped.
            wr_ptr    <= '0;
            wr_seg    <= '0;
            seg_off   <= '0;
            seg_valid <= '0;
            seg_done  <= 1'b0;
            full      <= 1'b0;
        end else begin
            seg_valid <= seg_valid_nxt;
            full      <= &seg_valid_nxt;
            seg_done  <= wr_fire && seg_last;
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (seg_last) begin
                    seg_idx <= wr_seg;
                    seg_off <= '0;
                    wr_seg  <= (wr_seg == SW'(NSEG - 1)) ? '0 : wr_seg + 1'b1;
                end else begin
                    seg_off <= seg_off + 1'b1;
                end
            end
        end
    end

    // Read qualifiers, judged on pre-update validity; frame_start does not affect them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_miss  <= rd_en && !rd_hit_c;
            hit_q    <= rd_en && rd_hit_c;
        end
    end

    ref_bank_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk (clk),
        .we  (wr_fire && !frame_start),
        .wa  (wr_ptr),
        .wd  (wr_data),
        .re  (rd_en && rd_hit_c),
        .ra  (rd_addr),
        .rd  (mem_q)
    );

    // The RAM register is not reset; gating with hit_q yields 0 on miss and after reset.
    assign rd_data = hit_q ? mem_q : '0;

endmodule

// File: tb/tb_ref_bank_ring.sv
// Directed bench for ref_bank_ring at default parameters.
module tb_ref_bank_ring;

    localparam int DW = 64;
    localparam int AW = 7;
    localparam int SW = 2;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic          wr_en;
    logic          bank_sel;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_miss;
    logic [AW-1:0] wr_ptr;
    logic          seg_done;
    logic [SW-1:0] seg_idx;
    logic          full;

    int total = 0;
    int bad   = 0;

    ref_bank_ring dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .bank_sel    (bank_sel),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_miss     (rd_miss),
        .wr_ptr      (wr_ptr),
        .seg_done    (seg_done),
        .seg_idx     (seg_idx),
        .full        (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] w(input int v);
        return DW'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        wr_en = 1'b1; bank_sel = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0; bank_sel = 1'b0;
    endtask

    task automatic rd_word(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        total++;
        if ({rd_data, rd_valid, rd_miss, wr_ptr, seg_done, seg_idx, full} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h v=%b m=%b ptr=%0d done=%b idx=%0d full=%b want all zero",
                     rd_data, rd_valid, rd_miss, wr_ptr, seg_done, seg_idx, full);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 23; i++) wr_word(w(i));
        total++;
        if (seg_done !== 1'b0) begin bad++; $display("FAIL fill_early_done: got %b want 0", seg_done); end
        wr_word(w(23));
        total++;
        if ({seg_done, seg_idx} !== {1'b1, 2'd0}) begin
            bad++; $display("FAIL fill_seg_done: got done=%b idx=%0d want done=1 idx=0", seg_done, seg_idx);
        end
        total++;
        if (wr_ptr !== 7'd24 || full !== 1'b0) begin
            bad++; $display("FAIL fill_ptr_full: got ptr=%0d full=%b want 24 0", wr_ptr, full);
        end
        rd_word(7'd5);
        total++;
        if ({rd_valid, rd_miss, rd_data} !== {1'b1, 1'b0, w(5)}) begin
            bad++; $display("FAIL fill_rd5: got v=%b m=%b data=%h want v=1 m=0 data=5", rd_valid, rd_miss, rd_data);
        end
        total++;
        if (seg_done !== 1'b0) begin bad++; $display("FAIL fill_done_pulse: got %b want 0", seg_done); end
        rd_word(7'd30);
        total++;
        if ({rd_valid, rd_miss, rd_data} !== {1'b1, 1'b1, w(0)}) begin
            bad++; $display("FAIL fill_rd30: got v=%b m=%b data=%h want v=1 m=1 data=0", rd_valid, rd_miss, rd_data);
        end
        step();
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_wrap();
        for (int i = 24; i < 96; i++) wr_word(w(i));
        total++;
        if (full !== 1'b1 || wr_ptr !== 7'd0) begin
            bad++; $display("FAIL wrap_full_ptr: got full=%b ptr=%0d want 1 0", full, wr_ptr);
        end
        total++;
        if ({seg_done, seg_idx} !== {1'b1, 2'd3}) begin
            bad++; $display("FAIL wrap_seg3_done: got done=%b idx=%0d want 1 3", seg_done, seg_idx);
        end
    endtask

    task automatic test_bank_sel();
        wr_en = 1'b1; bank_sel = 1'b0; wr_data = {8{8'hDE}};
        repeat (10) step();
        wr_en = 1'b0;
        total++;
        if (wr_ptr !== 7'd0 || full !== 1'b1) begin
            bad++; $display("FAIL bank_sel_ptr: got ptr=%0d full=%b want 0 1", wr_ptr, full);
        end
        rd_word(7'd0);
        total++;
        if ({rd_miss, rd_data} !== {1'b0, w(0)}) begin
            bad++; $display("FAIL bank_sel_mem0: got m=%b data=%h want m=0 data=0", rd_miss, rd_data);
        end
        rd_word(7'd96);
        total++;
        if ({rd_valid, rd_miss, rd_data} !== {1'b1, 1'b1, w(0)}) begin
            bad++; $display("FAIL rd_out_of_range: got v=%b m=%b data=%h want 1 1 0", rd_valid, rd_miss, rd_data);
        end
        rd_word(7'd95);
        total++;
        if ({rd_miss, rd_data} !== {1'b0, w(95)}) begin
            bad++; $display("FAIL rd_last_word: got m=%b data=%h want m=0 data=5f", rd_miss, rd_data);
        end
    endtask

    task automatic test_overwrite();
        wr_word({8{8'hAA}});
        total++;
        if (full !== 1'b0 || wr_ptr !== 7'd1) begin
            bad++; $display("FAIL overwrite_full_ptr: got full=%b ptr=%0d want 0 1", full, wr_ptr);
        end
        rd_word(7'd10);
        total++;
        if ({rd_miss, rd_data} !== {1'b1, w(0)}) begin
            bad++; $display("FAIL overwrite_rd10: got m=%b data=%h want m=1 data=0", rd_miss, rd_data);
        end
        rd_word(7'd50);
        total++;
        if ({rd_miss, rd_data} !== {1'b0, w(50)}) begin
            bad++; $display("FAIL overwrite_rd50: got m=%b data=%h want m=0 data=32", rd_miss, rd_data);
        end
    endtask

    task automatic test_collision();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++;
        if (wr_ptr !== 7'd0 || full !== 1'b0) begin
            bad++; $display("FAIL restart_ptr: got ptr=%0d full=%b want 0 0", wr_ptr, full);
        end
        rd_word(7'd50);
        total++;
        if (rd_miss !== 1'b1) begin bad++; $display("FAIL restart_rd50: got m=%b want 1", rd_miss); end
        for (int i = 0; i < 96; i++) wr_word(w(256 + i));
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL refill_full: got %b want 1", full); end
        wr_en = 1'b1; bank_sel = 1'b1; wr_data = {8{8'hFF}};
        rd_en = 1'b1; rd_addr = 7'd0;
        step();
        wr_en = 1'b0; bank_sel = 1'b0; rd_en = 1'b0;
        total++;
        if ({rd_valid, rd_miss, rd_data} !== {1'b1, 1'b0, w(256)}) begin
            bad++; $display("FAIL collision_read_first: got v=%b m=%b data=%h want 1 0 100", rd_valid, rd_miss, rd_data);
        end
        total++;
        if (full !== 1'b0 || wr_ptr !== 7'd1) begin
            bad++; $display("FAIL collision_state: got full=%b ptr=%0d want 0 1", full, wr_ptr);
        end
        rd_word(7'd0);
        total++;
        if ({rd_miss, rd_data} !== {1'b1, w(0)}) begin
            bad++; $display("FAIL collision_after: got m=%b data=%h want m=1 data=0", rd_miss, rd_data);
        end
    endtask

    task automatic test_frame_start();
        for (int i = 1; i < 23; i++) wr_word(w(1024 + i));
        total++;
        if (wr_ptr !== 7'd23) begin bad++; $display("FAIL fs_pre_ptr: got %0d want 23", wr_ptr); end
        wr_en = 1'b1; bank_sel = 1'b1; wr_data = w(1047); frame_start = 1'b1;
        rd_en = 1'b1; rd_addr = 7'd50;
        step();
        wr_en = 1'b0; bank_sel = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
        total++;
        if ({seg_done, wr_ptr, full} !== {1'b0, 7'd0, 1'b0}) begin
            bad++; $display("FAIL fs_state: got done=%b ptr=%0d full=%b want 0 0 0", seg_done, wr_ptr, full);
        end
        total++;
        if ({rd_valid, rd_miss, rd_data} !== {1'b1, 1'b0, w(306)}) begin
            bad++; $display("FAIL fs_same_cycle_read: got v=%b m=%b data=%h want 1 0 132", rd_valid, rd_miss, rd_data);
        end
        rd_word(7'd0);
        total++;
        if (rd_miss !== 1'b1) begin bad++; $display("FAIL fs_rd0: got m=%b want 1", rd_miss); end
        rd_word(7'd50);
        total++;
        if (rd_miss !== 1'b1) begin bad++; $display("FAIL fs_rd50: got m=%b want 1", rd_miss); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 50; i++) wr_word(w(512 + i));
        total++;
        if (wr_ptr !== 7'd50 || seg_idx !== 2'd1) begin
            bad++; $display("FAIL mid_pre: got ptr=%0d idx=%0d want 50 1", wr_ptr, seg_idx);
        end
        rd_en = 1'b1; rd_addr = 7'd30;
        step();
        rd_en = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if ({rd_data, rd_valid, rd_miss, wr_ptr, seg_done, seg_idx, full} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got data=%h v=%b m=%b ptr=%0d done=%b idx=%0d full=%b want all zero",
                     rd_data, rd_valid, rd_miss, wr_ptr, seg_done, seg_idx, full);
        end
        step();
        rst_n = 1'b1;
        step();
        wr_word(w(768));
        total++;
        if (wr_ptr !== 7'd1) begin bad++; $display("FAIL mid_restart_ptr: got %0d want 1", wr_ptr); end
        for (int i = 1; i < 24; i++) wr_word(w(768 + i));
        total++;
        if ({seg_done, seg_idx} !== {1'b1, 2'd0}) begin
            bad++; $display("FAIL mid_seg0_done: got done=%b idx=%0d want 1 0", seg_done, seg_idx);
        end
        rd_word(7'd0);
        total++;
        if ({rd_miss, rd_data} !== {1'b0, w(768)}) begin
            bad++; $display("FAIL mid_rd0: got m=%b data=%h want m=0 data=300", rd_miss, rd_data);
        end
        rd_word(7'd30);
        total++;
        if (rd_miss !== 1'b1) begin bad++; $display("FAIL mid_rd30: got m=%b want 1", rd_miss); end
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; wr_en = 1'b0; bank_sel = 1'b0;
        wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        test_reset();
        test_fill();
        test_wrap();
        test_bank_sel();
        test_overwrite();
        test_collision();
        test_frame_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
